// File: rtl/fixed_power.sv
// fixed_power: iterative unsigned fixed-point exponentiation, base**n.
// Uses one shared DATA_W x DATA_W multiply per cycle, truncating each product
// and saturating the result to all-ones on overflow.
module fixed_power #(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned FRAC_W = 10,
    parameter int unsigned EXP_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic [EXP_W-1:0]  in_data_2,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1) << FRAC_W;
    localparam logic [DATA_W-1:0] SAT = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_MULT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_base;
    logic [EXP_W-1:0]   r_exp;
    logic [DATA_W-1:0]  r_acc;
    logic [EXP_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_ovf;

    state_t             w_state_nxt;
    logic [DATA_W-1:0]  w_base_nxt;
    logic [EXP_W-1:0]   w_exp_nxt;
    logic [DATA_W-1:0]  w_acc_nxt;
    logic [EXP_W-1:0]   w_cnt_nxt;
    logic               w_ovf_nxt;
    logic               w_out_valid_nxt;
    logic [DATA_W-1:0]  w_out_data_nxt;
    logic               w_out_ovf_nxt;

    logic [PROD_W-1:0]  w_prod;
    logic [PROD_W-1:0]  w_q;
    logic               w_q_ovf;

    // Full-precision product, truncated back to the fixed-point grid.
    assign w_prod  = PROD_W'(r_acc) * PROD_W'(r_base);
    assign w_q     = w_prod >> FRAC_W;
    assign w_q_ovf = |w_q[PROD_W-1:DATA_W];

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_exp       <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_base      <= w_base_nxt;
            r_exp       <= w_exp_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ovf       <= w_ovf_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_ovf   <= w_out_ovf_nxt;
        end
    end

    // Next-state and next-register logic; the strobe defaults low, results hold.
    always_comb begin
        w_state_nxt     = r_state;
        w_base_nxt      = r_base;
        w_exp_nxt       = r_exp;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_ovf_nxt       = r_ovf;
        w_out_valid_nxt = 1'b0;
        w_out_data_nxt  = r_out_data;
        w_out_ovf_nxt   = r_out_ovf;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_base_nxt  = in_data_1;
                    w_exp_nxt   = in_data_2;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    w_base_nxt = in_data_1;
                    w_exp_nxt  = in_data_2;
                end else begin
                    w_acc_nxt   = ONE;
                    w_cnt_nxt   = r_exp;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = S_MULT;
                end
            end
            S_MULT: begin
                if (r_cnt != '0) begin
                    if (w_q_ovf || r_ovf) begin
                        w_acc_nxt = SAT;
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_acc_nxt = w_q[DATA_W-1:0];
                    end
                    w_cnt_nxt = r_cnt - EXP_W'(1);
                end else begin
                    w_out_data_nxt  = r_acc;
                    w_out_ovf_nxt   = r_ovf;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;

endmodule
